// File: rtl/fifo_pkg.sv
// Shared types for the read-side byte packer: byte width, packer states and the
// partial-word keep mask helper.
package fifo_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_FULL = 2'd2
   } pk_state_e;

   // Low cnt bits set; cnt=8 wraps through 9 bits to give all ones.
   function automatic logic [7:0] keep_mask(input logic [3:0] cnt);
      logic [8:0] one_hot;
      one_hot = 9'd1 << cnt;
      return 8'(one_hot - 9'd1);
   endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO pop side, flush request and packed word stream of the byte packer.
// master = packer side, slave = FIFO / downstream / control side.
interface fifo_rd_packer_if #(parameter int BYTES = 4);
   import fifo_pkg::*;

   logic                      i_fifo_rempty;
   logic [BYTE_W-1:0]         i_fifo_rdata;
   logic                      o_fifo_rd;
   logic                      i_flush;
   logic                      o_word_valid;
   logic                      i_word_ready;
   logic [BYTE_W*BYTES-1:0]   o_word_data;
   logic [BYTES-1:0]          o_word_keep;
   logic                      o_busy;

   modport master (
      input  i_fifo_rempty, i_fifo_rdata, i_flush, i_word_ready,
      output o_fifo_rd, o_word_valid, o_word_data, o_word_keep, o_busy
   );

   modport slave (
      output i_fifo_rempty, i_fifo_rdata, i_flush, i_word_ready,
      input  o_fifo_rd, o_word_valid, o_word_data, o_word_keep, o_busy
   );

endinterface

// File: rtl/fifo_word_out_reg.sv
// One-entry valid/ready holding register for a packed word and its keep mask;
// load lands next cycle, contents frozen while valid & !ready, reload allowed on the transfer cycle.
module fifo_word_out_reg #(
   parameter int W = 32,
   parameter int K = 4
) (
   input  logic         i_rclk,
   input  logic         i_rreset,
   input  logic         load,
   input  logic [W-1:0] load_dat,
   input  logic [K-1:0] load_keep,
   input  logic         out_rdy,
   output logic         out_vld,
   output logic [W-1:0] out_dat,
   output logic [K-1:0] out_keep,
   output logic         slot_free
);

   assign slot_free = !out_vld || out_rdy;

   always_ff @(posedge i_rclk) begin
      if (i_rreset) begin
         out_vld  <= 1'b0;
         out_dat  <= '0;
         out_keep <= '0;
      end else if (load) begin
         out_vld  <= 1'b1;
         out_dat  <= load_dat;
         out_keep <= load_keep;
      end else if (out_vld && out_rdy) begin
         out_vld  <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops bytes from a 1-cycle-latency FIFO and packs them LSB-lane-first into BYTES-wide words
// (last pop -> valid 3 cycles later); stalls pops when the output slot is held. FIFO_PACKER_TIMEOUT_EN adds idle auto-flush.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int BYTES       = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic             i_rclk,
   input  logic             i_rreset,
   fifo_rd_packer_if.master bus
);

   localparam int CNT_W  = $clog2(BYTES + 1);
   localparam int WORD_W = BYTE_W * BYTES;
   localparam logic [CNT_W:0] BYTES_C = (CNT_W + 1)'(BYTES);

   if (BYTES < 2 || BYTES > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
      $error("fifo_rd_packer: illegal BYTES or TIMEOUT_CYC");
   end

   pk_state_e          state, state_n;
   logic [CNT_W-1:0]   byte_cnt;
   logic               pend;
   logic               flush_req;
   logic [WORD_W-1:0]  asm_dat;
   logic               fifo_rd;
   logic               flush_done;
   logic               load_full;
   logic               load_flush;
   logic               load;
   logic [BYTES-1:0]   load_keep;
   logic               slot_free;
   logic               word_vld;
   logic               timeout_hit;

   always_ff @(posedge i_rclk) begin
      if (i_rreset) state <= S_IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n    = state;
      // In-flight byte counts against capacity so a pop never overfills the word.
      fifo_rd    = !i_rreset && !bus.i_fifo_rempty && !flush_req && (state != S_FULL) &&
                   (({1'b0, byte_cnt} + {{CNT_W{1'b0}}, pend}) < BYTES_C);
      flush_done = flush_req && !pend && slot_free;
      load_full  = (state == S_FULL) && slot_free;
      load_flush = flush_done && (state == S_FILL);
      unique case (state)
         S_IDLE: if (pend) state_n = S_FILL;
         S_FILL: begin
            if (pend && byte_cnt == CNT_W'(BYTES - 1)) state_n = S_FULL;
            else if (flush_done)                       state_n = S_IDLE;
         end
         S_FULL: if (slot_free) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign load      = load_full || load_flush;
   assign load_keep = load_full ? {BYTES{1'b1}} : BYTES'(keep_mask(4'(byte_cnt)));

   always_ff @(posedge i_rclk) begin
      if (i_rreset) begin
         byte_cnt  <= '0;
         pend      <= 1'b0;
         flush_req <= 1'b0;
         asm_dat   <= '0;
      end else begin
         pend <= fifo_rd;
         // Clearing on load keeps unused lanes of a later partial word at zero.
         if (load) begin
            byte_cnt <= '0;
            asm_dat  <= '0;
         end else if (pend) begin
            for (int lane = 0; lane < BYTES; lane++) begin
               if (byte_cnt == CNT_W'(lane)) asm_dat[lane*BYTE_W +: BYTE_W] <= bus.i_fifo_rdata;
            end
            byte_cnt <= byte_cnt + 1'b1;
         end
         if (flush_req) begin
            if (flush_done) flush_req <= 1'b0;
         end else if (bus.i_flush || timeout_hit) begin
            flush_req <= 1'b1;
         end
      end
   end

`ifdef FIFO_PACKER_TIMEOUT_EN
   logic [15:0] idle_cnt;

   always_ff @(posedge i_rclk) begin
      if (i_rreset)                                   idle_cnt <= '0;
      else if (state == S_FILL && !pend && !flush_req) idle_cnt <= idle_cnt + 16'd1;
      else                                            idle_cnt <= '0;
   end

   assign timeout_hit = (idle_cnt == 16'(TIMEOUT_CYC));
`else
   assign timeout_hit = 1'b0;
`endif

   fifo_word_out_reg #(.W(WORD_W), .K(BYTES)) u_out_reg (
      .i_rclk    (i_rclk),
      .i_rreset  (i_rreset),
      .load      (load),
      .load_dat  (asm_dat),
      .load_keep (load_keep),
      .out_rdy   (bus.i_word_ready),
      .out_vld   (word_vld),
      .out_dat   (bus.o_word_data),
      .out_keep  (bus.o_word_keep),
      .slot_free (slot_free)
   );

   assign bus.o_fifo_rd    = fifo_rd;
   assign bus.o_word_valid = word_vld;
   assign bus.o_busy       = (byte_cnt != '0) || pend || flush_req || word_vld;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a byte-queue FIFO model feeds the DUT, expected words are
// built by chunking the byte stream, and a monitor compares every accepted word.
module tb_fifo_rd_packer;
   import fifo_pkg::*;

   localparam int BYTES       = 4;
   localparam int TIMEOUT_CYC = 16;

   typedef struct packed {
      logic [8*BYTES-1:0] d;
      logic [BYTES-1:0]   k;
   } word_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_rd_packer_if #(.BYTES(BYTES)) bus();

   fifo_rd_packer #(.BYTES(BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .i_rclk   (clk),
      .i_rreset (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   int         words_seen = 0;
   int         pops = 0;
   logic [7:0] q[$];
   word_t      exp_q[$];
   bit         pop_pending = 0;
   logic [7:0] popped = '0;
   bit         rand_empty = 0;
   int         ready_mode = 0;
   bit         flush_next = 0;
   bit         rd_seen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: consecutive BYTES-sized chunks of the byte stream, optional partial tail.
   function automatic void expect_bytes(input logic [7:0] bs[$], input bit flush_tail);
      word_t w;
      int    lane;
      w    = '0;
      lane = 0;
      foreach (bs[i]) begin
         w.d[8*lane +: 8] = bs[i];
         w.k[lane]        = 1'b1;
         lane++;
         if (lane == BYTES) begin
            exp_q.push_back(w);
            w    = '0;
            lane = 0;
         end
      end
      if (flush_tail && lane != 0) exp_q.push_back(w);
   endfunction

   function automatic void feed(input logic [7:0] bs[$]);
      foreach (bs[i]) q.push_back(bs[i]);
   endfunction

   // One clock: drive inputs on the falling edge, sample the pop request just after.
   task automatic cycle(input bit do_rst);
      @(negedge clk);
      rst = do_rst;
      if (do_rst) begin
         q.delete();
         pop_pending = 0;
      end
      bus.i_fifo_rdata = pop_pending ? popped : 8'($urandom);
      bus.i_flush      = flush_next;
      flush_next       = 0;
      case (ready_mode)
         0:       bus.i_word_ready = 1'b1;
         1:       bus.i_word_ready = 1'b0;
         default: bus.i_word_ready = 1'($urandom_range(0, 1));
      endcase
      bus.i_fifo_rempty = (q.size() == 0) || (rand_empty && $urandom_range(0, 2) == 0);
      #1;
      rd_seen = bus.o_fifo_rd;
      if (bus.i_fifo_rempty) chk("rd_while_empty", 64'(bus.o_fifo_rd), 64'd0);
      pop_pending = 0;
      if (bus.o_fifo_rd && !bus.i_fifo_rempty && q.size() != 0) begin
         popped      = q.pop_front();
         pop_pending = 1;
         pops++;
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      bit done;
      n    = 0;
      done = 0;
      while (!done && n < budget) begin
         cycle(0);
         n++;
         done = (q.size() == 0) && !pop_pending && (exp_q.size() == 0) && !bus.o_busy;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s: not drained after %0d cycles, %0d words still expected", name, budget, exp_q.size());
      end
   endtask

   task automatic run_until_pops(input int target, input string name);
      int n;
      n = 0;
      while (pops < target && n < 200) begin
         cycle(0);
         n++;
      end
      chk(name, 64'(pops), 64'(target));
   endtask

   // Monitor: checks hold stability and pops the scoreboard on each transfer.
   bit    hold = 0;
   word_t held;
   word_t exp_w;
   always @(negedge clk) begin
      #2;
      if (rst) begin
         hold = 0;
      end else if (bus.o_word_valid) begin
         if (hold) chk("hold_stable", 64'({bus.o_word_data, bus.o_word_keep}), 64'(held));
         if (bus.i_word_ready) begin
            words_seen++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got %0h keep %0h expected no word", bus.o_word_data, bus.o_word_keep);
            end else begin
               exp_w = exp_q.pop_front();
               chk("word_data", 64'(bus.o_word_data), 64'(exp_w.d));
               chk("word_keep", 64'(bus.o_word_keep), 64'(exp_w.k));
            end
            hold = 0;
         end else begin
            hold = 1;
            held = {bus.o_word_data, bus.o_word_keep};
         end
      end else begin
         hold = 0;
      end
   end

   logic [7:0] bs[$];
   logic [7:0] bs2[$];
   int         seen0;

   initial begin
      bus.i_fifo_rempty = 1'b1;
      bus.i_fifo_rdata  = '0;
      bus.i_flush       = 1'b0;
      bus.i_word_ready  = 1'b1;

      repeat (3) cycle(1);
      chk("rst_valid", 64'(bus.o_word_valid), 64'd0);
      chk("rst_data",  64'(bus.o_word_data),  64'd0);
      chk("rst_keep",  64'(bus.o_word_keep),  64'd0);
      chk("rst_rd",    64'(bus.o_fifo_rd),    64'd0);
      chk("rst_busy",  64'(bus.o_busy),       64'd0);
      cycle(0);

      // Two full words, ready always high.
      bs.delete();
      for (int i = 1; i <= 8; i++) bs.push_back(8'(i * 8'h11));
      expect_bytes(bs, 0);
      feed(bs);
      wait_idle(200, "t1_drain");

      // Downstream stalled: one word held, one full word assembled, then pops stop.
      ready_mode = 1;
      pops = 0;
      bs.delete();
      for (int i = 1; i <= 12; i++) bs.push_back(8'(i));
      expect_bytes(bs, 0);
      feed(bs);
      repeat (40) cycle(0);
      chk("t2_pops", 64'(pops), 64'd8);
      chk("t2_rd_low", 64'(rd_seen), 64'd0);
      ready_mode = 0;
      wait_idle(200, "t2_drain");

      // Flush a 3-byte partial word, then flush with nothing held.
      pops = 0;
      bs.delete();
      for (int i = 1; i <= 3; i++) bs.push_back(8'(8'hA0 + i));
      expect_bytes(bs, 1);
      feed(bs);
      run_until_pops(3, "t3_pops");
      repeat (3) cycle(0);
      flush_next = 1;
      wait_idle(100, "t3_drain");
      seen0 = words_seen;
      flush_next = 1;
      repeat (10) cycle(0);
      chk("t3_empty_flush_words", 64'(words_seen - seen0), 64'd0);
      chk("t3_empty_flush_busy", 64'(bus.o_busy), 64'd0);

      // Flush while the second byte is still in flight.
      pops = 0;
      bs.delete();
      bs.push_back(8'hB1);
      bs.push_back(8'hB2);
      bs2.delete();
      for (int i = 1; i <= 4; i++) bs2.push_back(8'(8'hC0 + i));
      expect_bytes(bs, 1);
      expect_bytes(bs2, 0);
      feed(bs);
      run_until_pops(2, "t4_pops");
      flush_next = 1;
      cycle(0);
      feed(bs2);
      cycle(0);
      chk("t4_no_pop_during_flush", 64'(rd_seen), 64'd0);
      wait_idle(100, "t4_drain");

      // Random FIFO emptiness and random downstream readiness.
      rand_empty = 1;
      ready_mode = 2;
      for (int r = 0; r < 3; r++) begin
         bs.delete();
         for (int i = 0; i < 16; i++) bs.push_back(8'($urandom));
         expect_bytes(bs, 0);
         feed(bs);
         wait_idle(1000, "t5_drain");
      end
      rand_empty = 0;
      ready_mode = 0;

      // Reset with a partial word assembled.
      pops = 0;
      bs.delete();
      bs.push_back(8'hD1);
      bs.push_back(8'hD2);
      feed(bs);
      run_until_pops(2, "t6_pops");
      repeat (2) cycle(0);
      chk("t6_busy_before", 64'(bus.o_busy), 64'd1);
      cycle(1);
      cycle(0);
      chk("t6_valid", 64'(bus.o_word_valid), 64'd0);
      chk("t6_data",  64'(bus.o_word_data),  64'd0);
      chk("t6_keep",  64'(bus.o_word_keep),  64'd0);
      chk("t6_busy",  64'(bus.o_busy),       64'd0);
      chk("t6_rd",    64'(bus.o_fifo_rd),    64'd0);
      bs.delete();
      for (int i = 1; i <= 4; i++) bs.push_back(8'(8'hE0 + i));
      expect_bytes(bs, 0);
      feed(bs);
      wait_idle(100, "t6_drain");

      // Two bytes then silence.
      pops = 0;
      bs.delete();
      bs.push_back(8'hF1);
      bs.push_back(8'hF2);
      feed(bs);
      run_until_pops(2, "t7_pops");
`ifdef FIFO_PACKER_TIMEOUT_EN
      expect_bytes(bs, 1);
      wait_idle(60, "t7_timeout_drain");
`else
      seen0 = words_seen;
      repeat (40) cycle(0);
      chk("t7_no_auto_flush", 64'(words_seen - seen0), 64'd0);
      chk("t7_still_busy", 64'(bus.o_busy), 64'd1);
      expect_bytes(bs, 1);
      flush_next = 1;
      wait_idle(60, "t7_flush_drain");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
